// File: rtl/sum_accumulator_if.sv
// Sample-in / batch-total-out handshake bundle for sum_accumulator.
// master = producer of samples and consumer of totals; slave = the accumulator.
interface sum_accumulator_if #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_sum;
    logic                 in_cout;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_acc;
    logic                 out_ovf;
    logic [7:0]           sample_cnt;

    modport master (
        output in_valid, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, sample_cnt
    );

    modport slave (
        input  in_valid, in_sum, in_cout, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, sample_cnt
    );
endinterface

// File: rtl/sum_accumulator.sv
// Batch accumulator for {Cout,S} adder samples with a held, handshaked batch total.
// Optional macro SUM_ACC_SATURATE_EN: saturate the total on overflow instead of wrapping.
module sum_accumulator #(
    parameter int WIDTH       = 4,
    parameter int NUM_SAMPLES = 4,
    parameter int ACC_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    sum_accumulator_if.slave   bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_SAMPLES - 1);

    state_t               state_p1;
    logic [ACC_WIDTH-1:0] acc_p1;
    logic                 ovf_p1;
    logic [7:0]           cnt_p1;
    logic                 vld_p1;
    logic                 rdy_p1;

    logic [WIDTH:0]       sample_p0;
    logic [ACC_WIDTH:0]   raw_p0;
    logic [ACC_WIDTH:0]   nxt_p0;

    function automatic logic [ACC_WIDTH:0] wide_add(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [WIDTH:0]       smp
    );
        return {1'b0, acc} + {{(ACC_WIDTH - WIDTH){1'b0}}, smp};
    endfunction

`ifdef SUM_ACC_SATURATE_EN
    // Once the batch has overflowed the total is pinned at full scale until consumed.
    function automatic logic [ACC_WIDTH:0] saturate(
        input logic [ACC_WIDTH:0] raw,
        input logic               ovf
    );
        if (raw[ACC_WIDTH] || ovf)
            return {raw[ACC_WIDTH], {ACC_WIDTH{1'b1}}};
        return raw;
    endfunction
`endif

    // ---- stage p0: form sample and next total ----
    assign sample_p0 = {bus.in_cout, bus.in_sum};
    assign raw_p0    = wide_add(acc_p1, sample_p0);

`ifdef SUM_ACC_SATURATE_EN
    assign nxt_p0 = saturate(raw_p0, ovf_p1);
`else
    assign nxt_p0 = raw_p0;
`endif

    // ---- stage p1: batch state and registered outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= ACCUM;
            acc_p1   <= '0;
            ovf_p1   <= 1'b0;
            cnt_p1   <= '0;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b1;
        end else if (clear) begin
            state_p1 <= ACCUM;
            acc_p1   <= '0;
            ovf_p1   <= 1'b0;
            cnt_p1   <= '0;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b1;
        end else begin
            case (state_p1)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_p1 <= nxt_p0[ACC_WIDTH-1:0];
                        ovf_p1 <= ovf_p1 | raw_p0[ACC_WIDTH];
                        cnt_p1 <= cnt_p1 + 8'd1;
                        if (cnt_p1 == LAST_IDX) begin
                            state_p1 <= DONE;
                            vld_p1   <= 1'b1;
                            rdy_p1   <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Consumption frees the block next cycle; no sample is taken meanwhile.
                    if (bus.out_ready) begin
                        state_p1 <= ACCUM;
                        acc_p1   <= '0;
                        ovf_p1   <= 1'b0;
                        cnt_p1   <= '0;
                        vld_p1   <= 1'b0;
                        rdy_p1   <= 1'b1;
                    end
                end
                default: begin
                    state_p1 <= ACCUM;
                    vld_p1   <= 1'b0;
                    rdy_p1   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = rdy_p1;
    assign bus.out_valid  = vld_p1;
    assign bus.out_acc    = acc_p1;
    assign bus.out_ovf    = ovf_p1;
    assign bus.sample_cnt = cnt_p1;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed scenarios plus random traffic
// compared against a batch-sum reference model.
module tb_sum_accumulator;
    localparam int WIDTH = 4;
    localparam int NS    = 4;
    localparam int AW    = 5;
    localparam int MAXV  = (1 << AW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic clear1 = 1'b0;

    always #5 clk = ~clk;

    sum_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(AW)) bus ();
    sum_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(8))  bus1 ();

    sum_accumulator #(.WIDTH(WIDTH), .NUM_SAMPLES(NS), .ACC_WIDTH(AW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    sum_accumulator #(.WIDTH(WIDTH), .NUM_SAMPLES(1), .ACC_WIDTH(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear1),
        .bus   (bus1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: running arithmetic sum of the batch, samples taken, batch-complete flag.
    int m_sum  = 0;
    int m_cnt  = 0;
    bit m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_acc();
`ifdef SUM_ACC_SATURATE_EN
        return (m_sum > MAXV) ? MAXV : m_sum;
`else
        return m_sum % (MAXV + 1);
`endif
    endfunction

    task automatic model_reset();
        m_sum  = 0;
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".acc"},   32'(bus.out_acc),    32'(exp_acc()));
        check({tag, ".ovf"},   32'(bus.out_ovf),    32'(m_sum > MAXV));
        check({tag, ".cnt"},   32'(bus.sample_cnt), 32'(m_cnt));
        check({tag, ".valid"}, 32'(bus.out_valid),  32'(m_done));
        check({tag, ".ready"}, 32'(bus.in_ready),   32'(!m_done));
    endtask

    // One clock edge with the currently driven inputs, model update, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (clear) begin
            model_reset();
        end else if (!m_done) begin
            if (bus.in_valid) begin
                m_sum += int'({bus.in_cout, bus.in_sum});
                m_cnt++;
                if (m_cnt == NS) m_done = 1'b1;
            end
        end else if (bus.out_ready) begin
            model_reset();
        end
        #1;
        compare_all(tag);
    endtask

    task automatic put(input int v, input bit vld, input bit ordy, input bit clr, input string tag);
        logic [4:0] s;
        s             = 5'(v);
        bus.in_valid  = vld;
        bus.in_sum    = s[3:0];
        bus.in_cout   = s[4];
        bus.out_ready = ordy;
        clear         = clr;
        step(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vals[4];
        bit pat[7];
        int k;
        logic [4:0] r;

        bus.in_valid   = 1'b0;
        bus.in_sum     = '0;
        bus.in_cout    = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_sum    = '0;
        bus1.in_cout   = 1'b0;
        bus1.out_ready = 1'b0;

        // Reset state
        #12;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);

        // Basic batch 6,15,5,2
        vals = '{6, 15, 5, 2};
        for (int i = 0; i < 4; i++) put(vals[i], 1'b1, 1'b1, 1'b0, "basic");
        check("basic.total", 32'(bus.out_acc), 32'd28);
        check("basic.valid_after_last", 32'(bus.out_valid), 32'd1);
        put(0, 1'b0, 1'b1, 1'b0, "basic_consume");
        check("basic.acc_cleared", 32'(bus.out_acc), 32'd0);

        // Backpressure: total held, extra samples ignored
        for (int i = 0; i < 4; i++) put(vals[i], 1'b1, 1'b0, 1'b0, "bp_fill");
        for (int i = 0; i < 5; i++) begin
            put(9, 1'b1, 1'b0, 1'b0, "bp_hold");
            check("bp.total_stable", 32'(bus.out_acc), 32'd28);
        end
        put(9, 1'b1, 1'b1, 1'b0, "bp_consume");
        check("bp.released", 32'(bus.out_valid), 32'd0);

        // Overflow 31,31,0,0 at ACC_WIDTH=5
        vals = '{31, 31, 0, 0};
        for (int i = 0; i < 4; i++) put(vals[i], 1'b1, 1'b0, 1'b0, "ovf");
`ifdef SUM_ACC_SATURATE_EN
        check("ovf.total", 32'(bus.out_acc), 32'd31);
`else
        check("ovf.total", 32'(bus.out_acc), 32'd30);
`endif
        check("ovf.flag", 32'(bus.out_ovf), 32'd1);
        put(0, 1'b0, 1'b1, 1'b0, "ovf_consume");
        check("ovf.flag_cleared", 32'(bus.out_ovf), 32'd0);

        // Clear mid-batch drops partial total and the sample offered with it
        put(10, 1'b1, 1'b0, 1'b0, "clr_a");
        put(11, 1'b1, 1'b0, 1'b0, "clr_b");
        put(7, 1'b1, 1'b0, 1'b1, "clr_cycle");
        check("clr.cnt", 32'(bus.sample_cnt), 32'd0);
        for (int i = 0; i < 4; i++) put(4, 1'b1, 1'b0, 1'b0, "clr_next");
        check("clr.next_total", 32'(bus.out_acc), 32'd16);
        put(0, 1'b0, 1'b1, 1'b0, "clr_consume");

        // Asynchronous reset mid-cycle after two accepts
        put(3, 1'b1, 1'b0, 1'b0, "arst_a");
        put(5, 1'b1, 1'b0, 1'b0, "arst_b");
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst.acc", 32'(bus.out_acc), 32'd0);
        check("arst.cnt", 32'(bus.sample_cnt), 32'd0);
        check("arst.valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Gapped input
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        k = 1;
        for (int i = 0; i < 7; i++) begin
            check("gap.not_done_yet", 32'(bus.out_valid), 32'd0);
            put(pat[i] ? k : 25, pat[i], 1'b0, 1'b0, "gap");
            if (pat[i]) k++;
        end
        check("gap.total", 32'(bus.out_acc), 32'd10);
        put(0, 1'b0, 1'b1, 1'b0, "gap_consume");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = 5'($urandom_range(0, 31));
            put(int'(r), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 19) == 0), "rand");
        end
        put(0, 1'b0, 1'b1, 1'b0, "rand_drain");

        // NUM_SAMPLES=1: each accepted sample completes a batch
        for (int i = 0; i < 6; i++) begin
            r = 5'($urandom_range(0, 31));
            bus1.in_valid  = 1'b1;
            bus1.in_sum    = r[3:0];
            bus1.in_cout   = r[4];
            bus1.out_ready = 1'b0;
            @(posedge clk); #1;
            check("ns1.valid", 32'(bus1.out_valid), 32'd1);
            check("ns1.total", 32'(bus1.out_acc), 32'(r));
            bus1.out_ready = 1'b1;
            @(posedge clk); #1;
            check("ns1.consumed", 32'(bus1.out_valid), 32'd0);
            check("ns1.acc_zero", 32'(bus1.out_acc), 32'd0);
        end
        bus1.in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
